// File: rtl/dual_code_grant_seq.sv
// Takes a {first, second} code pair and issues the two one-hot grants in order.
// Each grant is held until it is acked or its hold timer runs out.
module dual_code_grant_seq #(
    parameter int N_REQ  = 12,
    parameter int CODE_W = 4,
    parameter int HOLD   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] first,
    input  logic [CODE_W-1:0] second,
    output logic [N_REQ-1:0]  grant,
    output logic [CODE_W-1:0] grant_code,
    input  logic              grant_ack,
    output logic              timeout,
    output logic              bad_code,
    output logic              done
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(N_REQ);

    typedef enum logic [1:0] {IDLE, G1, G2} state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  first_q, first_d;
    logic [CODE_W-1:0]  second_q, second_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               timeout_q, timeout_d;
    logic               bad_q, bad_d;
    logic               done_q, done_d;
    logic               accept;
    logic               end_g;

    // Out-of-range codes behave exactly like "no request".
    function automatic logic [CODE_W-1:0] clean(input logic [CODE_W-1:0] c);
        return (c > CODE_MAX) ? '0 : c;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
        logic [N_REQ-1:0] g;
        g = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (c == CODE_W'(i + 1)) g[i] = 1'b1;
        end
        return g;
    endfunction

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid & in_ready;
    assign end_g      = grant_ack | (cnt_q == CNT_LAST);
    assign grant      = grant_q;
    assign grant_code = code_q;
    assign timeout    = timeout_q;
    assign bad_code   = bad_q;
    assign done       = done_q;

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        second_d  = second_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        code_d    = code_q;
        timeout_d = 1'b0;
        bad_d     = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    first_d  = clean(first);
                    second_d = clean(second);
                    bad_d    = (first > CODE_MAX) | (second > CODE_MAX);
                    if (first_d != '0) begin
                        state_d = G1;
                        grant_d = onehot(first_d);
                        code_d  = first_d;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            G1: begin
                cnt_d = cnt_q + 1'b1;
                if (end_g) begin
                    timeout_d = ~grant_ack;
                    // Switch straight to the second grant, no idle gap.
                    if (second_q != '0 && second_q != first_q) begin
                        state_d = G2;
                        grant_d = onehot(second_q);
                        code_d  = second_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        code_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            G2: begin
                cnt_d = cnt_q + 1'b1;
                if (end_g) begin
                    timeout_d = ~grant_ack;
                    state_d   = IDLE;
                    grant_d   = '0;
                    code_d    = '0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            first_q   <= '0;
            second_q  <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            code_q    <= '0;
            timeout_q <= 1'b0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            second_q  <= second_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            code_q    <= code_d;
            timeout_q <= timeout_d;
            bad_q     <= bad_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_dual_code_grant_seq.sv
// Directed bench for dual_code_grant_seq.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_dual_code_grant_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  first;
    logic [3:0]  second;
    logic [11:0] grant;
    logic [3:0]  grant_code;
    logic        grant_ack;
    logic        timeout;
    logic        bad_code;
    logic        done;

    int total = 0;
    int bad = 0;

    dual_code_grant_seq #(.N_REQ(12), .CODE_W(4), .HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .first      (first),
        .second     (second),
        .grant      (grant),
        .grant_code (grant_code),
        .grant_ack  (grant_ack),
        .timeout    (timeout),
        .bad_code   (bad_code),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] f, input logic [3:0] s);
        in_valid = 1'b1;
        first    = f;
        second   = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_g(input string tag, input logic [11:0] g,
                         input logic [3:0] c);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".code"}, 32'(grant_code), 32'(c));
    endtask

    task automatic ack_step();
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        first     = '0;
        second    = '0;
        grant_ack = 1'b0;
        #3;
        chk_g("rst", 12'h000, 4'd0);
        chk("rst.ready", 32'(in_ready), 1);
        chk("rst.done", 32'(done), 0);
        chk("rst.to", 32'(timeout), 0);
        chk("rst.bad", 32'(bad_code), 0);
        rst_n = 1'b1;
        step();

        // ack while idle does nothing
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk_g("idle_ack", 12'h000, 4'd0);
        chk("idle_ack.ready", 32'(in_ready), 1);

        // 1: 12 then 5, ack after 2 cycles each
        send(4'd12, 4'd5);
        chk_g("t1.g1a", 12'h800, 4'd12);
        chk("t1.ready", 32'(in_ready), 0);
        step();
        chk_g("t1.g1b", 12'h800, 4'd12);
        ack_step();
        chk_g("t1.g2a", 12'h010, 4'd5);
        chk("t1.to1", 32'(timeout), 0);
        step();
        chk_g("t1.g2b", 12'h010, 4'd5);
        ack_step();
        chk_g("t1.end", 12'h000, 4'd0);
        chk("t1.done", 32'(done), 1);
        chk("t1.to2", 32'(timeout), 0);
        chk("t1.ready2", 32'(in_ready), 1);
        step();
        chk("t1.done_lo", 32'(done), 0);

        // 2: second=0 and second=first skip G2
        send(4'd3, 4'd0);
        chk_g("t2a.g1", 12'h004, 4'd3);
        ack_step();
        chk_g("t2a.end", 12'h000, 4'd0);
        chk("t2a.done", 32'(done), 1);
        send(4'd3, 4'd3);
        chk_g("t2b.g1", 12'h004, 4'd3);
        ack_step();
        chk_g("t2b.end", 12'h000, 4'd0);
        chk("t2b.done", 32'(done), 1);

        // 3: no ack, both grants time out after HOLD cycles
        send(4'd7, 4'd1);
        for (int i = 0; i < 4; i++) begin
            chk_g("t3.g1", 12'h040, 4'd7);
            chk("t3.to_a", 32'(timeout), 0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk_g("t3.g2", 12'h001, 4'd1);
            chk("t3.to_b", 32'(timeout), (i == 0) ? 1 : 0);
            step();
        end
        chk_g("t3.end", 12'h000, 4'd0);
        chk("t3.to_c", 32'(timeout), 1);
        chk("t3.done", 32'(done), 1);
        step();
        chk("t3.to_lo", 32'(timeout), 0);

        // ack on the expiry edge: no timeout
        send(4'd5, 4'd0);
        step();
        step();
        step();
        chk_g("tx.last", 12'h010, 4'd5);
        ack_step();
        chk_g("tx.end", 12'h000, 4'd0);
        chk("tx.to", 32'(timeout), 0);
        chk("tx.done", 32'(done), 1);

        // 4: out-of-range codes
        send(4'd14, 4'd2);
        chk("t4a.bad", 32'(bad_code), 1);
        chk("t4a.done", 32'(done), 1);
        chk("t4a.ready", 32'(in_ready), 1);
        chk_g("t4a.g", 12'h000, 4'd0);
        step();
        chk("t4a.bad_lo", 32'(bad_code), 0);
        send(4'd2, 4'd13);
        chk("t4b.bad", 32'(bad_code), 1);
        chk_g("t4b.g1", 12'h002, 4'd2);
        ack_step();
        chk_g("t4b.end", 12'h000, 4'd0);
        chk("t4b.done", 32'(done), 1);

        // 5: async reset during G2
        send(4'd1, 4'd2);
        ack_step();
        chk_g("t5.g2", 12'h002, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_g("t5.rst", 12'h000, 4'd0);
        chk("t5.ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        step();
        send(4'd4, 4'd0);
        chk_g("t5.next", 12'h008, 4'd4);
        ack_step();
        chk("t5.done", 32'(done), 1);

        // 6: in_valid held through a busy sequence
        in_valid = 1'b1;
        first    = 4'd6;
        second   = 4'd8;
        step();
        chk_g("t6.g1", 12'h020, 4'd6);
        first  = 4'd9;
        second = 4'd0;
        ack_step();
        chk_g("t6.g2", 12'h080, 4'd8);
        chk("t6.busy", 32'(in_ready), 0);
        ack_step();
        chk_g("t6.idle", 12'h000, 4'd0);
        chk("t6.done", 32'(done), 1);
        chk("t6.ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk_g("t6.new", 12'h100, 4'd9);
        chk("t6.done_lo", 32'(done), 0);
        ack_step();
        chk("t6.done2", 32'(done), 1);
        chk_g("t6.end", 12'h000, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
